lb_uart_rx: RTL and testbench
=============================

LB_UART_RX -- requirements
Module: lb_uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (LSB first, no parity, 1 stop bit).
REQ-002 Parameter OVERSAMPLE, default 16, baud-tick enables per bit period; even, >= 8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; state and outputs take reset values immediately on negedge reset.
REQ-005 baudTick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 cs  input  1  active-low chip select; qualifies rdAck.
REQ-008 rdAck  input  1  one-clk pulse: consumer has read rxData.
REQ-009 rxData  output  DATA_BITS  last correctly framed byte.
REQ-010 dataValid  output  1  rxData holds an unread byte.
REQ-011 frameError  output  1  sticky: stop bit sampled low.
REQ-012 overrun  output  1  sticky: byte completed while dataValid=1.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value rxS (2-clk latency).
REQ-015 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE; a tick counter (0..OVERSAMPLE-1) and a bit counter (0..DATA_BITS-1) SHALL advance only on baudTick.
REQ-016 IDLE: when rxS=0 SHALL go to START with tick counter cleared; otherwise remain.
REQ-017 START: at the OVERSAMPLE/2-th baudTick, rxS=0 -> DATA with both counters cleared; rxS=1 -> IDLE (glitch rejected, no flag).
REQ-018 DATA: at every OVERSAMPLE-th baudTick, rxS SHALL be shifted into the MSB of an internal shift register (LSB-first framing); after DATA_BITS samples go to STOP.
REQ-019 STOP: at the OVERSAMPLE-th baudTick, rxS=1 -> frame good, go to IDLE; rxS=0 -> frameError<=1, shift register discarded, go to WAIT_IDLE.
REQ-020 WAIT_IDLE: SHALL stay until rxS=1, then go to IDLE (no false start on a held break).
REQ-021 Good frame with dataValid=0 (after REQ-023 evaluation): rxData<=shift register and dataValid<=1 in the same clk the STOP sample is taken.
REQ-022 Good frame with dataValid=1 and no effective rdAck that clk: overrun<=1, rxData unchanged, new byte dropped.
REQ-023 Effective rdAck = rdAck & ~cs; it SHALL clear dataValid, frameError and overrun on the next edge; rdAck with cs=1 SHALL be ignored.
REQ-024 Effective rdAck in the same clk as a good-frame completion: new byte loaded, dataValid stays 1, overrun not set (and cleared).
REQ-025 rxData SHALL change only per REQ-021/REQ-024.
REQ-026 baudTick absent: FSM and counters SHALL hold; only synchronizer and rdAck handling continue.

Reset
REQ-027 On reset=0: state IDLE, counters 0, synchronizer flops 1, rxData=0, dataValid=0, frameError=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no flags set; after release the receiver SHALL wait for a new falling edge of rxS.

Verification
REQ-029 Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) at OVERSAMPLE=16 -> dataValid=1, rxData=0xA5, frameError=0, busy falls with dataValid rising.
REQ-030 rx low for 5 baudTicks then high -> returns to IDLE, dataValid=0, no flags; next valid 0x3C frame received correctly.
REQ-031 Frame 0x55 with stop bit=0, rx held low 40 ticks -> frameError=1, dataValid=0, busy=1 until rx returns high; rdAck with cs=0 clears frameError.
REQ-032 Two frames 0x11 then 0x22 without rdAck -> rxData=0x11, overrun=1; same sequence with rdAck (cs=0) on the completion clk of 0x22 -> rxData=0x22, dataValid=1, overrun=0.
REQ-033 rdAck pulses with cs=1 while dataValid=1 -> dataValid remains 1.
REQ-034 reset pulsed low during bit 4 of a frame -> all outputs at reset values; following frame 0xF0 received correctly.

Source files
------------

// File: rtl/lb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : lb_uart_rx
// Brief    : Oversampled UART receiver (8N1 by default) with single-entry
//            holding register, sticky frame-error / overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module lb_uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baudTick,
  input  logic                 rx,
  input  logic                 cs,
  input  logic                 rdAck,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 dataValid,
  output logic                 frameError,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int c_BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_MID  = c_TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_sync;
  logic [c_TICK_W-1:0]   r_tick_cnt;
  logic [c_TICK_W-1:0]   w_tick_nxt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_BIT_W-1:0]    w_bit_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic [DATA_BITS-1:0]  w_shift_in;
  logic [DATA_BITS-1:0]  r_rx_data;
  logic                  r_data_valid;
  logic                  r_frame_error;
  logic                  r_overrun;
  logic                  w_rxs;
  logic                  w_ack;
  logic                  w_frame_good;
  logic                  w_frame_bad;

  assign w_rxs = r_sync[1];
  assign w_ack = rdAck & ~cs;

  // LSB arrives first, so each new sample enters at the MSB and shifts down.
  generate
    if (DATA_BITS > 1) begin : g_shift_multi
      assign w_shift_in = {w_rxs, r_shift[DATA_BITS-1:1]};
    end else begin : g_shift_single
      assign w_shift_in = w_rxs;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_sync     <= {r_sync[0], rx};
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_frame_good = 1'b0;
    w_frame_bad  = 1'b0;
    if (baudTick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == c_TICK_MID) begin
            w_tick_nxt = '0;
            w_bit_nxt  = '0;
            // A start bit that is high again at mid-bit is treated as noise.
            w_state_nxt = w_rxs ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
          end
        end
        S_DATA: begin
          if (r_tick_cnt == c_TICK_LAST) begin
            w_tick_nxt  = '0;
            w_shift_nxt = w_shift_in;
            if (r_bit_cnt == c_BIT_LAST) begin
              w_bit_nxt   = '0;
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + c_BIT_W'(1);
            end
          end else begin
            w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
          end
        end
        S_STOP: begin
          if (r_tick_cnt == c_TICK_LAST) begin
            w_tick_nxt = '0;
            if (w_rxs) begin
              w_frame_good = 1'b1;
              w_state_nxt  = S_IDLE;
            end else begin
              w_frame_bad = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + c_TICK_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end
  end

  // Holding register: an acknowledge in the completion clock frees the slot
  // for the new byte instead of flagging an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data     <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_frame_good && (!r_data_valid || w_ack)) begin
        r_rx_data    <= r_shift;
        r_data_valid <= 1'b1;
      end else if (w_ack) begin
        r_data_valid <= 1'b0;
      end

      if (w_ack) begin
        r_overrun <= 1'b0;
      end else if (w_frame_good && r_data_valid) begin
        r_overrun <= 1'b1;
      end

      if (w_frame_bad) begin
        r_frame_error <= 1'b1;
      end else if (w_ack) begin
        r_frame_error <= 1'b0;
      end
    end
  end

  assign rxData     = r_rx_data;
  assign dataValid  = r_data_valid;
  assign frameError = r_frame_error;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_uart_rx
// Brief    : Self-checking bench for lb_uart_rx against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
  localparam int FRAME_CLKS = (DATA_BITS + 2) * BIT_CLKS;
  // Line falls one clk after a tick: 2-clk sync, next tick enters START,
  // OVERSAMPLE/2 ticks to mid-start, then OVERSAMPLE ticks per data/stop bit.
  localparam int COMPLETE_OFF = 3 + (OVERSAMPLE / 2) * TICK_DIV + (DATA_BITS + 1) * BIT_CLKS;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 baudTick;
  logic                 rx;
  logic                 cs;
  logic                 rdAck;
  logic [DATA_BITS-1:0] rxData;
  logic                 dataValid;
  logic                 frameError;
  logic                 overrun;
  logic                 busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] m_data;
  bit         m_valid, m_fe, m_ov;

  lb_uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .baudTick  (baudTick),
    .rx        (rx),
    .cs        (cs),
    .rdAck     (rdAck),
    .rxData    (rxData),
    .dataValid (dataValid),
    .frameError(frameError),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    baudTick = 1'b0;
    forever begin
      @(negedge clk);
      baudTick = (cyc % TICK_DIV == 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit exp_busy);
    check({tag, ".rxData"},     32'(rxData),     32'(m_data));
    check({tag, ".dataValid"},  32'(dataValid),  32'(m_valid));
    check({tag, ".frameError"}, 32'(frameError), 32'(m_fe));
    check({tag, ".overrun"},    32'(overrun),    32'(m_ov));
    check({tag, ".busy"},       32'(busy),       32'(exp_busy));
  endtask

  function automatic void model_reset();
    m_data = '0; m_valid = 0; m_fe = 0; m_ov = 0;
  endfunction

  function automatic void model_ack();
    m_valid = 0; m_fe = 0; m_ov = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit stop_ok, input bit ack_same);
    if (stop_ok) begin
      if (!m_valid || ack_same) begin
        m_data  = d;
        m_valid = 1;
      end else begin
        m_ov = 1;
      end
      if (ack_same) begin
        m_ov = 0;
        m_fe = 0;
      end
    end else begin
      if (ack_same) begin
        m_valid = 0;
        m_ov    = 0;
      end
      m_fe = 1;
    end
  endfunction

  task automatic align();
    do @(negedge clk); while (cyc % TICK_DIV != 1);
  endtask

  task automatic do_ack(input logic ack_cs);
    @(negedge clk);
    rdAck = 1'b1;
    cs    = ack_cs;
    @(negedge clk);
    rdAck = 1'b0;
    cs    = 1'b1;
    if (!ack_cs) model_ack();
  endtask

  // Drives one full frame; checks the clock before and after the stop sample.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int ack_off,
                            input logic ack_cs, input string tag);
    logic [9:0] bits;
    bits = {stop_ok, d, 1'b0};
    align();
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (c == COMPLETE_OFF) begin
        check({tag, ".busy_pre"},  32'(busy), 32'd1);
        check({tag, ".valid_pre"}, 32'(dataValid), 32'(m_valid));
      end
      if (c == COMPLETE_OFF + 1) begin
        model_frame(d, stop_ok, (ack_off == COMPLETE_OFF) && (ack_cs == 1'b0));
        check_outputs({tag, ".done"}, !stop_ok);
      end
      rx    = bits[c / BIT_CLKS];
      rdAck = (c == ack_off);
      cs    = (c == ack_off) ? ack_cs : 1'b1;
      @(negedge clk);
    end
    rdAck = 1'b0;
    cs    = 1'b1;
  endtask

  task automatic release_break(input int low_ticks);
    repeat (low_ticks * TICK_DIV) @(negedge clk);
    check("break.busy_held", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (4 * TICK_DIV) @(negedge clk);
    check("break.busy_released", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pre_bits;
    logic [9:0] part;
    rx = 1'b1; cs = 1'b1; rdAck = 1'b0; reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame
    send_frame(8'hA5, 1'b1, -1, 1'b1, "a5");
    check_outputs("a5.idle", 1'b0);
    do_ack(1'b0);
    check_outputs("a5.ack", 1'b0);

    // Short low glitch
    align();
    rx = 1'b0;
    repeat (5 * TICK_DIV) @(negedge clk);
    check("glitch.busy_in_start", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (10 * TICK_DIV) @(negedge clk);
    check_outputs("glitch.rejected", 1'b0);
    send_frame(8'h3C, 1'b1, -1, 1'b1, "3c");
    do_ack(1'b0);

    // Framing error with held break
    send_frame(8'h55, 1'b0, -1, 1'b1, "55bad");
    release_break(40);
    check_outputs("55bad.after", 1'b0);
    do_ack(1'b0);
    check_outputs("55bad.ack", 1'b0);

    // Overrun, then acknowledge in the completion clock
    send_frame(8'h11, 1'b1, -1, 1'b1, "ov11");
    send_frame(8'h22, 1'b1, -1, 1'b1, "ov22");
    check_outputs("overrun", 1'b0);
    do_ack(1'b0);
    send_frame(8'h11, 1'b1, -1, 1'b1, "sa11");
    send_frame(8'h22, 1'b1, COMPLETE_OFF, 1'b0, "sa22");
    check_outputs("same_clk_ack", 1'b0);
    do_ack(1'b1);
    check_outputs("ack_cs_high", 1'b0);
    do_ack(1'b1);
    check("ack_cs_high2.valid", 32'(dataValid), 32'd1);

    // Asynchronous reset during bit 4
    pre_bits = 8'h9A;
    part = {1'b1, pre_bits, 1'b0};
    align();
    for (int c = 0; c < 5 * BIT_CLKS + BIT_CLKS / 2; c++) begin
      rx = part[c / BIT_CLKS];
      @(negedge clk);
    end
    #2 reset = 1'b0;
    model_reset();
    #1 check_outputs("midreset.async", 1'b0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_outputs("midreset.after", 1'b0);
    send_frame(8'hF0, 1'b1, -1, 1'b1, "f0");

    // Randomized traffic
    for (int i = 0; i < 14; i++) begin
      logic [7:0] d;
      bit         ok;
      int         mode;
      string      tag;
      d    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      mode = $urandom_range(0, 4);
      tag  = $sformatf("rnd%0d", i);
      if (mode == 3) do_ack(1'b0);
      if (mode == 4) do_ack(1'b1);
      if (mode == 1 && ok)
        send_frame(d, ok, COMPLETE_OFF, 1'b0, tag);
      else if (mode == 2)
        send_frame(d, ok, COMPLETE_OFF, 1'b1, tag);
      else
        send_frame(d, ok, -1, 1'b1, tag);
      if (!ok) release_break($urandom_range(1, 20));
      check_outputs({tag, ".end"}, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
